// File: rtl/combo_lock_ctrl_pkg.sv
// Shared types and constants for the combination-lock attempt sequencer.
package combo_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned FAIL_W  = 3;

  typedef enum logic [2:0] {
    StClear,
    StEntry,
    StWaitResult,
    StOpen,
    StLockout
  } state_e;

  // Lock-core status as {fail, open}; fail takes precedence when both are raised.
  typedef enum logic [1:0] {
    StatusNone = 2'b00,
    StatusOpen = 2'b01,
    StatusFail = 2'b10
  } status_e;

  function automatic status_e decode_status(input logic open, input logic fail);
    if (fail) return StatusFail;
    if (open) return StatusOpen;
    return StatusNone;
  endfunction

endpackage

// File: rtl/combo_lock_ctrl_if.sv
// User digit handshake, lock-core link and status outputs of the attempt sequencer.
interface combo_lock_ctrl_if;
  import combo_pkg::*;

  logic [DIGIT_W-1:0] digit;
  logic               digit_valid;
  logic               digit_ready;
  logic               relock;
  logic [DIGIT_W-1:0] lock_code;
  logic               lock_code_valid;
  logic               lock_rst;
  logic               lock_open;
  logic               lock_fail;
  logic               unlocked;
  logic               locked_out;
  logic [FAIL_W-1:0]  fail_count;

  modport master (
    input  digit, digit_valid, relock, lock_open, lock_fail,
    output digit_ready, lock_code, lock_code_valid, lock_rst, unlocked, locked_out, fail_count
  );

  modport slave (
    output digit, digit_valid, relock, lock_open, lock_fail,
    input  digit_ready, lock_code, lock_code_valid, lock_rst, unlocked, locked_out, fail_count
  );

endinterface

// File: rtl/combo_lockout_timer.sv
// Loadable down-counter; done fires on the tick that consumes the final count.
module combo_lockout_timer #(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               tick_i,
  input  logic               clear_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               done_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  assign done_o = tick_i && (count_q == TIMER_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/combo_lock_ctrl.sv
// Attempt sequencer: replays user digits into the lock core, judges the result,
// counts consecutive failures and enforces a timed lockout.
module combo_lock_ctrl
  import combo_pkg::*;
#(
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned RESP_TIMEOUT   = 4,
  parameter int unsigned TIMER_W        = 8
) (
  input logic               CLK,
  input logic               RST,
  input logic               masterRST,
  combo_lock_ctrl_if.master bus
);

  localparam logic [3:0]        LastDigit = 4'(CODE_LEN - 1);
  localparam logic [3:0]        RespLimit = 4'(RESP_TIMEOUT);
  localparam logic [FAIL_W-1:0] FailMax   = FAIL_W'(MAX_FAILS);

  state_e             state_q, state_d;
  logic [3:0]         dig_cnt_q, dig_cnt_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic [FAIL_W-1:0]  fail_count_q, fail_count_d, fail_sat;
  logic [DIGIT_W-1:0] lock_code_q, lock_code_d;
  logic               code_valid_q, code_valid_d;
  logic               lock_rst_q, lock_rst_d;
  logic               digit_ready_q, digit_ready_d;
  logic               unlocked_q, unlocked_d;
  logic               locked_out_q, locked_out_d;
  logic               accept, timer_load, timer_done;
  status_e            status;

  assign accept   = (state_q == StEntry) && digit_ready_q && bus.digit_valid;
  assign status   = decode_status(bus.lock_open, bus.lock_fail);
  assign fail_sat = (fail_count_q == FailMax) ? fail_count_q : fail_count_q + FAIL_W'(1);

  always_comb begin
    state_d      = state_q;
    dig_cnt_d    = dig_cnt_q;
    wait_cnt_d   = '0;
    fail_count_d = fail_count_q;
    lock_code_d  = lock_code_q;
    code_valid_d = 1'b0;
    timer_load   = 1'b0;

    unique case (state_q)
      StClear: begin
        dig_cnt_d = '0;
        // Stay until the lock_rst pulse has actually been presented (covers the reset entry).
        if (lock_rst_q) state_d = StEntry;
      end
      StEntry: begin
        if (accept) begin
          lock_code_d  = bus.digit;
          code_valid_d = 1'b1;
          dig_cnt_d    = dig_cnt_q + 4'd1;
          if (dig_cnt_q == LastDigit) state_d = StWaitResult;
        end
      end
      StWaitResult: begin
        wait_cnt_d = wait_cnt_q + 4'd1;
        if (status == StatusOpen) begin
          state_d      = StOpen;
          fail_count_d = '0;
        end else if ((status == StatusFail) || (wait_cnt_q == RespLimit)) begin
          fail_count_d = fail_sat;
          if (fail_sat == FailMax) begin
            state_d    = StLockout;
            timer_load = 1'b1;
          end else begin
            state_d = StClear;
          end
        end
      end
      StOpen: begin
        if (bus.relock) state_d = StClear;
      end
      StLockout: begin
        if (timer_done) begin
          state_d      = StClear;
          fail_count_d = '0;
        end
      end
      default: state_d = StClear;
    endcase

    if (masterRST) begin
      state_d      = StClear;
      fail_count_d = '0;
      dig_cnt_d    = '0;
      wait_cnt_d   = '0;
      lock_code_d  = lock_code_q;
      code_valid_d = 1'b0;
      timer_load   = 1'b0;
    end

    lock_rst_d    = (state_d == StClear);
    digit_ready_d = (state_d == StEntry);
    unlocked_d    = (state_d == StOpen);
    locked_out_d  = (state_d == StLockout);
  end

  combo_lockout_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (timer_load),
    .tick_i    (state_q == StLockout),
    .clear_i   (masterRST),
    .load_val_i(TIMER_W'(LOCKOUT_CYCLES)),
    .done_o    (timer_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StClear;
      dig_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      fail_count_q  <= '0;
      lock_code_q   <= '0;
      code_valid_q  <= 1'b0;
      lock_rst_q    <= 1'b0;
      digit_ready_q <= 1'b0;
      unlocked_q    <= 1'b0;
      locked_out_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      dig_cnt_q     <= dig_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      fail_count_q  <= fail_count_d;
      lock_code_q   <= lock_code_d;
      code_valid_q  <= code_valid_d;
      lock_rst_q    <= lock_rst_d;
      digit_ready_q <= digit_ready_d;
      unlocked_q    <= unlocked_d;
      locked_out_q  <= locked_out_d;
    end
  end

  assign bus.digit_ready     = digit_ready_q;
  assign bus.lock_code       = lock_code_q;
  assign bus.lock_code_valid = code_valid_q;
  assign bus.lock_rst        = lock_rst_q;
  assign bus.unlocked        = unlocked_q;
  assign bus.locked_out      = locked_out_q;
  assign bus.fail_count      = fail_count_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl; outputs are {lock_rst, digit_ready, lock_code_valid,
// unlocked, locked_out} sampled 1 ns after each rising edge.
module tb_combo_lock_ctrl;

  logic CLK = 1'b0;
  logic RST;
  logic masterRST;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  combo_lock_ctrl_if bus();

  combo_lock_ctrl #(
    .CODE_LEN      (4),
    .MAX_FAILS     (3),
    .LOCKOUT_CYCLES(16),
    .RESP_TIMEOUT  (4),
    .TIMER_W       (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .masterRST(masterRST),
    .bus      (bus)
  );

  function automatic logic [4:0] obs();
    return {bus.lock_rst, bus.digit_ready, bus.lock_code_valid, bus.unlocked, bus.locked_out};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Starts in an ENTRY cycle, ends in the first WAIT_RESULT cycle with valid dropped.
  task automatic send_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      bus.digit       = code[15-4*i -: 4];
      bus.digit_valid = 1'b1;
      step();
    end
    bus.digit_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    checks++;
    if (obs() !== 5'b00000 || bus.fail_count !== 3'd0 || bus.lock_code !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: outs=%b fail=%0d code=%0d want outs=00000 fail=0 code=0",
               obs(), bus.fail_count, bus.lock_code);
    end
    RST = 1'b0;
    step();
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL reset_cycle1: outs=%b want 10000", obs());
    end
    step();
    checks++;
    if (obs() !== 5'b01000 || bus.fail_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_cycle2: outs=%b fail=%0d want outs=01000 fail=0", obs(), bus.fail_count);
    end
  endtask

  task automatic test_unlock();
    logic [3:0] d [4];
    d = '{4'd3, 4'd7, 4'd1, 4'd9};
    for (int i = 0; i < 4; i++) begin
      bus.digit       = d[i];
      bus.digit_valid = 1'b1;
      step();
      checks++;
      if (bus.lock_code_valid !== 1'b1 || bus.lock_code !== d[i]) begin
        errors++;
        $display("FAIL unlock_digit%0d: valid=%b code=%0d want valid=1 code=%0d",
                 i, bus.lock_code_valid, bus.lock_code, d[i]);
      end
    end
    bus.digit_valid = 1'b0;
    checks++;
    if (bus.digit_ready !== 1'b0) begin
      errors++;
      $display("FAIL unlock_ready_drop: ready=%b want 0", bus.digit_ready);
    end
    bus.lock_open = 1'b1;
    step();
    bus.lock_open = 1'b0;
    checks++;
    if (obs() !== 5'b00010 || bus.fail_count !== 3'd0) begin
      errors++;
      $display("FAIL unlock_open: outs=%b fail=%0d want outs=00010 fail=0", obs(), bus.fail_count);
    end
    bus.relock = 1'b1;
    step();
    bus.relock = 1'b0;
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL unlock_relock: outs=%b want 10000", obs());
    end
    step();
  endtask

  task automatic test_fail_lockout();
    for (int a = 1; a <= 3; a++) begin
      send_code(16'h1234);
      bus.lock_fail = 1'b1;
      step();
      bus.lock_fail = 1'b0;
      checks++;
      if (bus.fail_count !== 3'(a)) begin
        errors++;
        $display("FAIL lockout_count%0d: fail=%0d want %0d", a, bus.fail_count, a);
      end
      if (a < 3) begin
        checks++;
        if (obs() !== 5'b10000) begin
          errors++;
          $display("FAIL lockout_retry%0d: outs=%b want 10000", a, obs());
        end
        step();
      end
    end
    checks++;
    if (obs() !== 5'b00001) begin
      errors++;
      $display("FAIL lockout_enter: outs=%b want 00001", obs());
    end
    bus.digit_valid = 1'b1;
    bus.relock      = 1'b1;
    for (int n = 2; n <= 16; n++) begin
      step();
      checks++;
      if (obs() !== 5'b00001 || bus.fail_count !== 3'd3) begin
        errors++;
        $display("FAIL lockout_cycle%0d: outs=%b fail=%0d want outs=00001 fail=3",
                 n, obs(), bus.fail_count);
      end
    end
    bus.digit_valid = 1'b0;
    bus.relock      = 1'b0;
    step();
    checks++;
    if (obs() !== 5'b10000 || bus.fail_count !== 3'd0) begin
      errors++;
      $display("FAIL lockout_exit: outs=%b fail=%0d want outs=10000 fail=0", obs(), bus.fail_count);
    end
    step();
  endtask

  task automatic test_timeout();
    send_code(16'h5555);
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (obs() !== 5'b00000 || bus.fail_count !== 3'd0) begin
        errors++;
        $display("FAIL timeout_wait%0d: outs=%b fail=%0d want outs=00000 fail=0",
                 i, obs(), bus.fail_count);
      end
    end
    step();
    checks++;
    if (obs() !== 5'b10000 || bus.fail_count !== 3'd1) begin
      errors++;
      $display("FAIL timeout_fail: outs=%b fail=%0d want outs=10000 fail=1", obs(), bus.fail_count);
    end
    step();
  endtask

  task automatic test_master_rst();
    send_code(16'h2222);
    bus.lock_fail = 1'b1;
    step();
    bus.lock_fail = 1'b0;
    checks++;
    if (bus.fail_count !== 3'd2) begin
      errors++;
      $display("FAIL master_pre_fail: fail=%0d want 2", bus.fail_count);
    end
    step();
    send_code(16'h2222);
    bus.lock_fail = 1'b1;
    step();
    bus.lock_fail = 1'b0;
    checks++;
    if (obs() !== 5'b00001) begin
      errors++;
      $display("FAIL master_lockout: outs=%b want 00001", obs());
    end
    repeat (4) step();
    masterRST = 1'b1;
    step();
    masterRST = 1'b0;
    checks++;
    if (obs() !== 5'b10000 || bus.fail_count !== 3'd0) begin
      errors++;
      $display("FAIL master_abort_lockout: outs=%b fail=%0d want outs=10000 fail=0",
               obs(), bus.fail_count);
    end
    step();
    // Two digits, then abort: a fresh attempt must need all four digits again.
    for (int i = 0; i < 2; i++) begin
      bus.digit       = 4'(i + 1);
      bus.digit_valid = 1'b1;
      step();
    end
    bus.digit_valid = 1'b0;
    masterRST = 1'b1;
    step();
    masterRST = 1'b0;
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL master_abort_partial: outs=%b want 10000", obs());
    end
    step();
    for (int i = 0; i < 3; i++) begin
      bus.digit       = 4'(i + 5);
      bus.digit_valid = 1'b1;
      step();
    end
    bus.digit_valid = 1'b0;
    checks++;
    if (bus.digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL master_digit_restart: ready=%b want 1", bus.digit_ready);
    end
    bus.digit       = 4'd8;
    bus.digit_valid = 1'b1;
    step();
    bus.digit_valid = 1'b0;
    checks++;
    if (obs() !== 5'b00100 || bus.lock_code !== 4'd8) begin
      errors++;
      $display("FAIL master_fourth_digit: outs=%b code=%0d want outs=00100 code=8",
               obs(), bus.lock_code);
    end
    bus.lock_open = 1'b1;
    step();
    bus.lock_open = 1'b0;
    masterRST = 1'b1;
    step();
    masterRST = 1'b0;
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL master_relock_open: outs=%b want 10000", obs());
    end
    step();
    bus.digit       = 4'hA;
    bus.digit_valid = 1'b1;
    masterRST       = 1'b1;
    step();
    bus.digit_valid = 1'b0;
    masterRST       = 1'b0;
    checks++;
    if (obs() !== 5'b10000) begin
      errors++;
      $display("FAIL master_suppress_valid: outs=%b want 10000", obs());
    end
    step();
  endtask

  task automatic test_both_status();
    send_code(16'h9876);
    bus.lock_open = 1'b1;
    bus.lock_fail = 1'b1;
    step();
    bus.lock_open = 1'b0;
    bus.lock_fail = 1'b0;
    checks++;
    if (obs() !== 5'b10000 || bus.fail_count !== 3'd1) begin
      errors++;
      $display("FAIL both_status: outs=%b fail=%0d want outs=10000 fail=1", obs(), bus.fail_count);
    end
    step();
    checks++;
    if (obs() !== 5'b01000) begin
      errors++;
      $display("FAIL both_status_reentry: outs=%b want 01000", obs());
    end
  endtask

  initial begin
    RST             = 1'b1;
    masterRST       = 1'b0;
    bus.digit       = '0;
    bus.digit_valid = 1'b0;
    bus.relock      = 1'b0;
    bus.lock_open   = 1'b0;
    bus.lock_fail   = 1'b0;
    test_reset();
    test_unlock();
    test_fail_lockout();
    test_timeout();
    test_master_rst();
    test_both_status();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
